// File: rtl/sic_nibble_framer_if.sv
// sic_nibble_framer_if: byte stream leaving the framer FIFO, valid/ready handshake.
interface sic_nibble_framer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sic_nibble_framer.sv
// sic_nibble_framer: hunts a sync nibble on the SIC parallel word, then packs
// nibble pairs into bytes and queues them in a small valid/ready FIFO.
module sic_nibble_framer #(
    parameter logic [3:0] SYNC        = 4'b1011,
    parameter int          FRAME_BYTES = 2,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            q_in,
    input  logic                  shift_en,
    sic_nibble_framer_if.master   stream,
    output logic                  locked,
    output logic                  overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]    state;
    logic [1:0]    bit_cnt;
    logic [3:0]    byte_cnt;
    logic          hi_pending;
    logic [3:0]    hi;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          nib, push, pop, full, valid, do_push, last;

    // a nibble boundary is the fourth shift after sync or after the previous nibble
    assign nib     = shift_en && state == COLLECT && bit_cnt == 2'd3;
    assign push    = nib && hi_pending;
    assign valid   = count != '0;
    assign full    = count == CW'(FIFO_DEPTH);
    assign pop     = valid && stream.out_ready;
    assign do_push = push && (!full || pop);
    assign last    = push && byte_cnt == 4'(FRAME_BYTES - 1);

    assign stream.out_valid = valid;
    assign stream.out_data  = mem[rd_ptr];
    assign locked           = state == COLLECT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            hi_pending <= 1'b0;
            hi         <= '0;
        end else if (shift_en) begin
            if (state == HUNT) begin
                if (q_in == SYNC) begin
                    state      <= COLLECT;
                    bit_cnt    <= '0;
                    byte_cnt   <= '0;
                    hi_pending <= 1'b0;
                end
            end else begin
                bit_cnt <= bit_cnt + 2'd1;
                if (nib && !hi_pending) begin
                    hi         <= q_in;
                    hi_pending <= 1'b1;
                end else if (push) begin
                    hi_pending <= 1'b0;
                    byte_cnt   <= last ? '0 : byte_cnt + 4'd1;
                    if (last)
                        state <= HUNT;
                end
            end
        end
    end

    // storage is reset too so out_data reads zero straight out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {hi, q_in};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && full && !pop)
                overflow <= 1'b1;
            count <= count + CW'(do_push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_sic_nibble_framer.sv
// tb_sic_nibble_framer: directed and random bit streams checked every cycle
// against a bit-queue/byte-queue reference model of the framer.
module tb_sic_nibble_framer;
    localparam logic [3:0] SYNC  = 4'b1011;
    localparam int         FB    = 2;
    localparam int         DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] q_in = '0;
    logic       shift_en = 1'b0;
    logic       locked, overflow;

    sic_nibble_framer_if bus();

    sic_nibble_framer #(.SYNC(SYNC), .FRAME_BYTES(FB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .q_in(q_in), .shift_en(shift_en),
        .stream(bus.master), .locked(locked), .overflow(overflow));

    always #5 clk = ~clk;

    int         tests = 0, fails = 0;
    logic [3:0] sr = '0;
    bit         m_lock = 0, m_ovf = 0;
    bit         bits_q[$];
    logic [7:0] mq[$];
    int         m_bytes = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset;
        m_lock = 0; m_ovf = 0; m_bytes = 0; sr = '0;
        bits_q.delete(); mq.delete();
    endtask

    // one clock: drive inputs, advance the model at the edge, compare at negedge
    task automatic cyc(input bit se, input bit b, input bit rdy);
        bit pop;
        logic [7:0] byt;
        if (se) begin
            sr = {sr[2:0], b};
            q_in = sr;
        end else
            q_in = 4'($urandom);
        shift_en = se;
        bus.out_ready = rdy;
        @(posedge clk);
        pop = rdy && mq.size() > 0;
        if (se) begin
            if (!m_lock) begin
                if (sr == SYNC) begin
                    m_lock = 1; m_bytes = 0; bits_q.delete();
                end
            end else begin
                bits_q.push_back(b);
                if (bits_q.size() == 8) begin
                    byt = '0;
                    foreach (bits_q[i]) byt = {byt[6:0], bits_q[i]};
                    bits_q.delete();
                    if (mq.size() < DEPTH || pop) mq.push_back(byt);
                    else m_ovf = 1;
                    m_bytes++;
                    if (m_bytes == FB) m_lock = 0;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        @(negedge clk);
        check("valid", 8'(bus.out_valid), 8'(mq.size() > 0));
        check("locked", 8'(locked), 8'(m_lock));
        check("overflow", 8'(overflow), 8'(m_ovf));
        if (mq.size() > 0) check("data", bus.out_data, mq[0]);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, v[i], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit rdy_last);
        for (int i = 7; i >= 0; i--) cyc(1'b1, v[i], i == 0 ? rdy_last : 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input int nb, input bit rdy_last);
        send_bits(16'h000B, 8);
        send_byte(a, nb == 1 ? rdy_last : 1'b0);
        if (nb == 2) send_byte(b, rdy_last);
    endtask

    task automatic drain(input logic [7:0] e);
        check("drain", bus.out_data, e);
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic async_reset;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 8'(bus.out_valid), 8'h00);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_locked", 8'(locked), 8'h00);
        check("rst_ovf", 8'(overflow), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("init_valid", 8'(bus.out_valid), 8'h00);
        check("init_data", bus.out_data, 8'h00);
        check("init_locked", 8'(locked), 8'h00);
        check("init_ovf", 8'(overflow), 8'h00);
        rst_n = 1'b1;
        model_reset();

        send_bits(16'h000B, 4);
        check("s2_lock", 8'(locked), 8'h01);
        send_bits(16'h002E, 7);
        check("s2_not_yet", 8'(bus.out_valid), 8'h00);
        cyc(1'b1, 1'b0, 1'b0);
        check("s2_valid", 8'(bus.out_valid), 8'h01);
        check("s2_data", bus.out_data, 8'h5C);

        send_bits(16'h00A3, 8);
        check("s3_unlock", 8'(locked), 8'h00);
        check("s3_head", bus.out_data, 8'h5C);
        send_bits(16'h0005, 5);
        check("s3_noise", 8'(locked), 8'h00);
        cyc(1'b1, 1'b1, 1'b0);
        check("s3_relock", 8'(locked), 8'h01);
        async_reset();

        send_frame(8'h11, 8'h22, 2, 1'b0);
        send_frame(8'h33, 8'h44, 2, 1'b0);
        check("s4_no_ovf_yet", 8'(overflow), 8'h00);
        send_frame(8'h55, 8'h00, 1, 1'b0);
        check("s4_ovf", 8'(overflow), 8'h01);
        check("s4_head", bus.out_data, 8'h11);
        drain(8'h11); drain(8'h22); drain(8'h33); drain(8'h44);
        check("s4_empty", 8'(bus.out_valid), 8'h00);
        async_reset();

        send_frame(8'h11, 8'h22, 2, 1'b0);
        send_frame(8'h33, 8'h44, 2, 1'b0);
        send_frame(8'h55, 8'h00, 1, 1'b1);
        check("s5_ovf", 8'(overflow), 8'h00);
        drain(8'h22); drain(8'h33); drain(8'h44); drain(8'h55);
        check("s5_empty", 8'(bus.out_valid), 8'h00);
        async_reset();

        begin
            logic [11:0] s = 12'hB5C;
            for (int i = 11; i >= 0; i--) begin
                repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
                cyc(1'b1, s[i], 1'b0);
            end
        end
        check("s6_valid", 8'(bus.out_valid), 8'h01);
        check("s6_data", bus.out_data, 8'h5C);
        async_reset();

        repeat (3000) cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 1)));
        async_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
